// File: rtl/dmem_rmw_ctrl_if.sv
// Request/response and data-RAM bus for dmem_rmw_ctrl.
// The slave modport is the controller; master is the pipeline/RAM/SLU side.
interface dmem_rmw_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              req_valid;
  logic [31:0]       req_addr;
  logic [3:0]        req_access;
  logic [31:0]       req_wd;
  logic [31:0]       slu_wd;
  logic [31:0]       rsp_rdata;
  logic              rsp_valid;
  logic              stall;
  logic              misalign_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_addr, req_access, req_wd, slu_wd, mem_rdata,
    input  rsp_rdata, rsp_valid, stall, misalign_err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_access, req_wd, slu_wd, mem_rdata,
    output rsp_rdata, rsp_valid, stall, misalign_err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_rmw_ctrl.sv
// Data-RAM sequencer: word reads for loads, read-modify-write for sh/sb, single-cycle sw.
// Strobes, stall and rsp_valid decode from state so reset silences them immediately.
module dmem_rmw_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  dmem_rmw_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  localparam logic [3:0] AccLw  = 4'd1;
  localparam logic [3:0] AccLh  = 4'd2;
  localparam logic [3:0] AccLb  = 4'd3;
  localparam logic [3:0] AccLhu = 4'd4;
  localparam logic [3:0] AccLbu = 4'd5;
  localparam logic [3:0] AccSw  = 4'd6;
  localparam logic [3:0] AccSh  = 4'd7;
  localparam logic [3:0] AccSb  = 4'd8;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        access_q, access_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              req_ld, req_sw, req_rmw, req_mis, q_ld, q_rmw;
  logic [ADDR_W-1:0] req_waddr;
  logic              unused_addr;

  assign req_waddr   = bus_io.req_addr[ADDR_W+1:2];
  assign unused_addr = ^bus_io.req_addr[31:ADDR_W+2];

  always_comb begin
    req_ld  = bus_io.req_access inside {AccLw, AccLh, AccLb, AccLhu, AccLbu};
    req_sw  = (bus_io.req_access == AccSw);
    req_rmw = bus_io.req_access inside {AccSh, AccSb};
    q_ld    = access_q inside {AccLw, AccLh, AccLb, AccLhu, AccLbu};
    q_rmw   = access_q inside {AccSh, AccSb};
    req_mis = 1'b0;
    if (bus_io.req_access inside {AccLw, AccSw}) begin
      req_mis = |bus_io.req_addr[1:0];
    end else if (bus_io.req_access inside {AccLh, AccLhu, AccSh}) begin
      req_mis = bus_io.req_addr[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    access_d = access_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid && !req_mis && (req_ld || req_rmw)) begin
          state_d  = StRead;
          cnt_d    = 3'(RD_LAT - 1);
          addr_d   = req_waddr;
          access_d = bus_io.req_access;
        end
      end
      StRead: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rdata_d = bus_io.mem_rdata;
          state_d = q_rmw ? StWrite : StDone;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      access_q <= 4'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      access_q <= access_d;
      rdata_q  <= rdata_d;
    end
  end

  // IDLE decodes straight from the request; gating on rst keeps a held request quiet in reset.
  always_comb begin
    bus_io.mem_re       = 1'b0;
    bus_io.mem_we       = 1'b0;
    bus_io.mem_wdata    = 32'd0;
    bus_io.mem_addr     = addr_q;
    bus_io.stall        = 1'b0;
    bus_io.rsp_valid    = 1'b0;
    bus_io.misalign_err = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          bus_io.mem_addr = req_waddr;
          if (bus_io.req_valid) begin
            if (req_mis) begin
              bus_io.misalign_err = 1'b1;
            end else if (req_sw) begin
              bus_io.mem_we    = 1'b1;
              bus_io.mem_wdata = bus_io.req_wd;
            end else if (req_ld || req_rmw) begin
              bus_io.mem_re = 1'b1;
              bus_io.stall  = 1'b1;
            end
          end
        end
        StRead: bus_io.stall = 1'b1;
        StWrite: begin
          bus_io.stall     = 1'b1;
          bus_io.mem_we    = 1'b1;
          bus_io.mem_wdata = bus_io.slu_wd;
        end
        StDone:  bus_io.rsp_valid = q_ld;
        default: ;
      endcase
    end
  end

  assign bus_io.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: one DUT at RD_LAT=1 and one at RD_LAT=3 sharing a RAM model,
// checked cycle by cycle against a transaction-level timeline and a reference memory.
module tb_dmem_rmw_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned NW = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel3;
  logic        req_valid;
  logic [3:0]  req_access;
  logic [31:0] req_addr, req_wd;

  dmem_rmw_ctrl_if #(.ADDR_W(AW)) b1 ();
  dmem_rmw_ctrl_if #(.ADDR_W(AW)) b3 ();

  dmem_rmw_ctrl #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus_io(b1));
  dmem_rmw_ctrl #(.ADDR_W(AW), .RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus_io(b3));

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [3:0] acc,
                                        input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (acc == 4'd7) begin
      if (lo[1]) r[31:16] = wd[15:0];
      else       r[15:0]  = wd[15:0];
    end else if (acc == 4'd8) begin
      r[{lo, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction

  assign b1.req_valid  = req_valid & ~sel3;
  assign b3.req_valid  = req_valid & sel3;
  assign b1.req_access = req_access;
  assign b3.req_access = req_access;
  assign b1.req_addr   = req_addr;
  assign b3.req_addr   = req_addr;
  assign b1.req_wd     = req_wd;
  assign b3.req_wd     = req_wd;
  assign b1.slu_wd     = merge(b1.rsp_rdata, req_access, req_addr[1:0], req_wd);
  assign b3.slu_wd     = merge(b3.rsp_rdata, req_access, req_addr[1:0], req_wd);

  // RAM model: read data is driven only in the cycle it is due, garbage otherwise.
  logic [31:0]   ram [0:NW-1];
  logic          clr = 1'b0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = 32'd0;
  logic          p1_v = 1'b0;
  logic [31:0]   p1_d = 32'd0;
  logic [2:0]    p3_v = 3'd0;
  logic [31:0]   p3_d [3];

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < NW; i++) ram[i] <= 32'd0;
    if (pre_we)   ram[pre_addr]    <= pre_data;
    if (b1.mem_we) ram[b1.mem_addr] <= b1.mem_wdata;
    if (b3.mem_we) ram[b3.mem_addr] <= b3.mem_wdata;
    p1_v    <= b1.mem_re;
    p1_d    <= ram[b1.mem_addr];
    p3_v    <= {p3_v[1:0], b3.mem_re};
    p3_d[0] <= ram[b3.mem_addr];
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
  end

  assign b1.mem_rdata = p1_v    ? p1_d    : 32'hBADD_A7A1;
  assign b3.mem_rdata = p3_v[2] ? p3_d[2] : 32'hBADD_A7A3;

  logic [4:0]    o_ctrl;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_wdata, o_rdata;
  assign o_ctrl  = sel3 ? {b3.stall, b3.mem_re, b3.mem_we, b3.rsp_valid, b3.misalign_err}
                        : {b1.stall, b1.mem_re, b1.mem_we, b1.rsp_valid, b1.misalign_err};
  assign o_addr  = sel3 ? b3.mem_addr  : b1.mem_addr;
  assign o_wdata = sel3 ? b3.mem_wdata : b1.mem_wdata;
  assign o_rdata = sel3 ? b3.rsp_rdata : b1.rsp_rdata;

  logic [31:0] ref_mem [0:NW-1];
  logic [31:0] exp_rd [2];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic preload(input int wa, input logic [31:0] w);
    req_valid   = 1'b0;
    pre_we      = 1'b1;
    pre_addr    = AW'(wa);
    pre_data    = w;
    ref_mem[wa] = w;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // One transaction; called just after a rising edge, returns just after the edge ending it.
  task automatic run_txn(input bit s3, input bit valid, input logic [3:0] acc,
                         input logic [31:0] addr, input logic [31:0] wd, input bit drop,
                         output int lat_meas, output bit mis_seen, output logic [31:0] word);
    int L, lat, wa;
    bit ld, sw, rmw, mis;
    bit e_stall, e_re, e_we, e_rv, e_mis;
    logic [31:0] old, merged, ld_word;
    L   = s3 ? 3 : 1;
    mis = ((acc == 4'd1 || acc == 4'd6) && addr[1:0] != 2'd0) ||
          ((acc == 4'd2 || acc == 4'd4 || acc == 4'd7) && addr[0]);
    mis = mis && valid;
    ld  = valid && !mis && acc >= 4'd1 && acc <= 4'd5;
    sw  = valid && !mis && acc == 4'd6;
    rmw = valid && !mis && (acc == 4'd7 || acc == 4'd8);
    lat = ld ? L + 2 : (rmw ? L + 3 : 1);
    wa  = int'(addr[AW+1:2]);
    old = ref_mem[wa];
    merged = merge(old, acc, addr[1:0], wd);
    sel3 = s3; req_valid = valid; req_access = acc; req_addr = addr; req_wd = wd;
    lat_meas = 0; mis_seen = 1'b0; ld_word = 32'd0;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      e_stall = (k < lat - 1);
      e_re    = (ld || rmw) && k == 0;
      e_we    = (sw && k == 0) || (rmw && k == L + 1);
      e_rv    = ld && k == lat - 1;
      e_mis   = mis && k == 0;
      chk($sformatf("ctrl acc%0d k%0d", acc, k), 32'(o_ctrl),
          32'({e_stall, e_re, e_we, e_rv, e_mis}));
      if (e_re || e_we) chk("mem_addr", 32'(o_addr), 32'(wa));
      chk("mem_wdata", o_wdata, e_we ? (sw ? wd : merged) : 32'd0);
      if ((ld || rmw) && k == L + 1) exp_rd[s3] = old;
      chk("rsp_rdata", o_rdata, exp_rd[s3]);
      if (o_ctrl[4] == 1'b0 && lat_meas == 0) lat_meas = k + 1;
      if (k == 0) mis_seen = o_ctrl[0];
      ld_word = o_rdata;
      @(posedge clk);
      #1;
      if (drop && k == 0) req_valid = 1'b0;
    end
    if (sw)  ref_mem[wa] = wd;
    if (rmw) ref_mem[wa] = merged;
    word = ld ? ld_word : ram[wa];
  endtask

  typedef struct {
    bit          s3;
    logic [3:0]  acc;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          init;
    logic [31:0] init_w;
    int          cyc;
    bit          mis;
    logic [31:0] word;
  } vec_t;

  vec_t vt [12];

  initial begin
    int lat;
    bit mis;
    logic [31:0] word;

    vt[0]  = '{0, 4'd1, 32'h10, 32'h0,        1, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF};
    vt[1]  = '{0, 4'd8, 32'h13, 32'hAA,       1, 32'h11223344, 4, 0, 32'hAA223344};
    vt[2]  = '{0, 4'd6, 32'h20, 32'h12345678, 0, 32'h0,        1, 0, 32'h12345678};
    vt[3]  = '{0, 4'd2, 32'h21, 32'h0,        0, 32'h0,        1, 1, 32'h12345678};
    vt[4]  = '{0, 4'd6, 32'h22, 32'hFFFFFFFF, 0, 32'h0,        1, 1, 32'h12345678};
    vt[5]  = '{1, 4'd5, 32'h31, 32'h0,        1, 32'hCAFEF00D, 5, 0, 32'hCAFEF00D};
    vt[6]  = '{1, 4'd7, 32'h32, 32'h0000BEEF, 0, 32'h0,        6, 0, 32'hBEEFF00D};
    vt[7]  = '{1, 4'd0, 32'h40, 32'h0,        0, 32'h0,        1, 0, 32'h0};
    vt[8]  = '{1, 4'd4, 32'h26, 32'h0,        1, 32'h01020304, 5, 0, 32'h01020304};
    vt[9]  = '{0, 4'd9, 32'h00, 32'h0,        0, 32'h0,        1, 0, 32'h0};
    vt[10] = '{0, 4'd7, 32'h22, 32'h00005555, 0, 32'h0,        4, 0, 32'h55555678};
    vt[11] = '{1, 4'd3, 32'h4B, 32'h0,        1, 32'h0A0B0C0D, 5, 0, 32'h0A0B0C0D};

    sel3 = 1'b0; req_valid = 1'b0; req_access = 4'd0; req_addr = 32'd0; req_wd = 32'd0;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'd0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel3 = s[0];
      #1;
      chk("reset ctrl", 32'(o_ctrl), 32'd0);
      chk("reset rdata", o_rdata, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      if (vt[i].init) preload(int'(vt[i].addr[AW+1:2]), vt[i].init_w);
      run_txn(vt[i].s3, 1'b1, vt[i].acc, vt[i].addr, vt[i].wd, 1'b0, lat, mis, word);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].cyc));
      chk($sformatf("vec%0d misalign", i), 32'(mis), 32'(vt[i].mis));
      chk($sformatf("vec%0d word", i), word, vt[i].word);
    end

    req_valid = 1'b0;
    @(negedge clk);
    chk("idle ctrl", 32'(o_ctrl), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a RD_LAT=3 load.
    sel3 = 1'b1; req_valid = 1'b1; req_access = 4'd1; req_addr = 32'h14;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre-reset stall", 32'(o_ctrl[4]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("reset mid-read ctrl", 32'(o_ctrl), 32'd0);
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    @(posedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b1, 4'd6, 32'h50, 32'h0BADCAFE, 1'b0, lat, mis, word);
    chk("post-reset sw latency", 32'(lat), 32'd1);
    chk("post-reset sw word", word, 32'h0BADCAFE);

    for (int i = 0; i < 32; i++) preload(i, $urandom);

    for (int n = 0; n < 400; n++) begin
      bit s3, valid, drop;
      logic [3:0] acc;
      logic [31:0] addr;
      s3    = 1'($urandom_range(0, 1));
      valid = ($urandom_range(0, 9) != 0);
      drop  = ($urandom_range(0, 3) == 0);
      acc   = 4'($urandom_range(0, 10));
      addr  = 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
      run_txn(s3, valid, acc, addr, $urandom, drop, lat, mis, word);
      if ($urandom_range(0, 4) == 0) begin
        req_valid = 1'b0;
        @(negedge clk);
        chk("random idle ctrl", 32'(o_ctrl), 32'd0);
        @(posedge clk);
        #1;
      end
    end

    for (int i = 0; i < 32; i++) chk($sformatf("ram word %0d", i), ram[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
